mul_div_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide engine and its sequencing FSM for the execute stage. It accepts one M-extension operation from ID/EX when the execute result mux selects the mul/div path. It iterates the operation over a fixed number of cycles and holds the pipeline with `busy` until the result is ready. It replaces the single-cycle combinational multiplier path and cancels cleanly on a branch/jump flush.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/mul_div_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// State encoding, func3 opcodes, default width and special-case result constants.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN_DEF-1:0] DIV_ZERO_RES = '1;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply or restoring divide.
// Purely combinational; accumulator is {high half, low half} of a 2*XLEN register.
// No flow control; the sequencer decides when the step result is captured.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   sum;
  logic [2*XLEN:0] mul_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_sh;

  always_comb begin
    sum     = '0;
    mul_sh  = '0;
    trial   = '0;
    rem_sh  = '0;
    acc_nxt = acc;
    if (is_div) begin
      // Low half holds the dividend being shifted out and the quotient shifted in.
      trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
      rem_sh = {acc[2*XLEN-2:XLEN], acc[XLEN-1]};
      if (!trial[XLEN]) begin
        acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {rem_sh, acc[XLEN-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
      mul_sh  = {sum, acc[XLEN-1:0]};
      acc_nxt = mul_sh[2*XLEN:1];
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle RV32M mul/div engine; MUL_DIV_FAST_MUL_EN computes multiplies in one step.
// Latency: 35 cycles start-to-done (2 for div special cases, 3 for fast multiplies).
// Holds the pipeline with busy in PREP/CALC/FIN; flush cancels without done.
module mul_div_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;

  logic              is_div, a_signed, b_signed, a_neg, b_neg, neg_calc;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Operand conditioning, valid while in PREP (operands are still raw then).
  always_comb begin
    is_div   = is_div_op(op);
    a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    a_neg    = a_signed && a_reg[XLEN-1];
    b_neg    = b_signed && b_reg[XLEN-1];
    abs_a    = a_neg ? (~a_reg + 1'b1) : a_reg;
    abs_b    = b_neg ? (~b_reg + 1'b1) : b_reg;
    neg_calc = (op == F3_REM) ? a_neg : (a_neg ^ b_neg);

    div_zero = (b_reg == '0);
    div_ovf  = ((op == F3_DIV) || (op == F3_REM)) && (a_reg == SMIN) && (b_reg == '1);
    special  = is_div && (div_zero || div_ovf);

    special_res = XLEN'(DIV_ZERO_RES);
    if (div_zero) begin
      if ((op == F3_REM) || (op == F3_REMU)) special_res = a_reg;
    end else if (op == F3_REM) begin
      special_res = '0;
    end else begin
      special_res = SMIN;
    end
  end

`ifdef MUL_DIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (b_reg),
    .acc_nxt (acc_step)
  );

  // Sign correction and output selection for FIN.
  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_res ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                        fin_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fin_res = quo_fix;
      default:                       fin_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !flush) state_nxt = ST_PREP;
      ST_PREP: begin
        if (flush)        state_nxt = ST_IDLE;
        else if (special) state_nxt = ST_DONE;
`ifdef MUL_DIV_FAST_MUL_EN
        else if (!is_div) state_nxt = ST_FIN;
`endif
        else              state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (flush)          state_nxt = ST_IDLE;
        else if (cnt == '0) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op    <= func3;
            a_reg <= operand_a;
            b_reg <= operand_b;
          end
        end
        ST_PREP: begin
          // Multiplier and dividend both start in the low half of the accumulator.
          acc     <= {{XLEN{1'b0}}, abs_a};
          b_reg   <= abs_b;
          cnt     <= CNT_W'(XLEN - 1);
          neg_res <= neg_calc;
`ifdef MUL_DIV_FAST_MUL_EN
          if (!is_div) acc <= fast_prod;
`endif
          if (special && !flush) result <= special_res;
        end
        ST_CALC: begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FIN: begin
          if (!flush) result <= fin_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: reference model via native SV arithmetic.
module tb_mul_div_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         start;
  logic [2:0]   func3;
  logic [W-1:0] operand_a, operand_b;
  logic         flush;
  logic         busy, done;
  logic [W-1:0] result;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  always #5 CLK = ~CLK;

  mul_div_sequencer #(.XLEN(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .func3     (func3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      F3_MULH:   begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 2;
    if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Scoreboard consumer: every done must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("result", 64'(result), 64'(last_exp));
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int want_lat;
    bit busy_ok;
    want_lat = exp_latency(f, a, b);
    @(negedge CLK);
    exp_q.push_back(model(f, a, b));
    func3 = f; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 60) begin
      @(negedge CLK);
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check("latency", 64'(lat), 64'(want_lat));
    check("busy_window", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    RESET = 1'b0; start = 1'b0; flush = 1'b0;
    func3 = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    RESET = 1'b1;

    // start together with flush in IDLE must not launch an op
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; func3 = F3_MUL; operand_a = 32'd2; operand_b = 32'd2;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check("start_flush_ignored", 64'(busy), 64'd0);

    run_op(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD);
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(F3_DIV,    32'hFFFF_FFEC, 32'd6);
    run_op(F3_REM,    32'hFFFF_FFEC, 32'd6);
    run_op(F3_DIVU,   32'd100, 32'd7);
    run_op(F3_REMU,   32'd100, 32'd7);
    run_op(F3_DIVU,   32'd5, 32'd0);
    run_op(F3_REM,    32'd5, 32'd0);
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F3_MUL,    32'h0001_0000, 32'h0001_0000);
    run_op(F3_MULH,   32'h0001_0000, 32'h0001_0000);

    // flush during CALC: no done, result keeps last committed value
    @(negedge CLK);
    func3 = F3_DIV; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'd0);
      end
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen |= done;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_result_held", 64'(result), 64'(last_exp));

    run_op(F3_MUL, 32'd3, 32'd4);

    // synchronous reset in the middle of an op
    @(negedge CLK);
    func3 = F3_MULHU; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK);
      if (c == 20) RESET = 1'b0;
      if (c == 21) begin
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        RESET = 1'b1;
      end
    end
    last_exp = '0;
    run_op(F3_DIVU, 32'd100, 32'd7);

    // flush arriving in the DONE cycle must not suppress done
    @(negedge CLK);
    exp_q.push_back(model(F3_DIVU, 32'd9, 32'd0));
    func3 = F3_DIVU; operand_a = 32'd9; operand_b = 32'd0; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(posedge CLK);
    #1 flush = 1'b1;
    @(negedge CLK);
    check("done_under_flush", 64'(done), 64'd1);
    @(posedge CLK);
    #1 flush = 1'b0;
    @(negedge CLK);
    check("idle_after_flush_done", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), (i == 3) ? 32'd0 : W'($urandom_range(1, 1000)));
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
